// File: rtl/piradip_cdc_pkg.sv
// piradip_cdc_pkg: shared CDC mode enum, width limit and gray decoder
package piradip_cdc_pkg;
  typedef enum logic {CDC_MODE_STABLE, CDC_MODE_GRAY} cdc_mode_t;
  localparam int GRAY_MAX_W = 256;
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    for (int i = 0; i < GRAY_MAX_W; i++) b[i] = ^(g >> i);
    return b;
  endfunction
endpackage

// File: rtl/piradip_cdc_stable_chan.sv
// piradip_cdc_stable_chan: one channel of synchroniser plus stability filter or gray decode
module piradip_cdc_stable_chan
  import piradip_cdc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STAGES = 4,
  parameter int STABLE_CYCLES = 4,
  parameter cdc_mode_t MODE = CDC_MODE_STABLE,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             dst_clk,
  input  logic             dst_rst_n,
  input  logic [WIDTH-1:0] async_data,
  output logic [WIDTH-1:0] dst_data,
  output logic             dst_load,
  output logic             dst_update,
  output logic             dst_valid
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] s, p_q, b, nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic accept;
  if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
    $error("STAGES must be 2..8");
  end
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_stable
    $error("STABLE_CYCLES must be 1..255");
  end
  if (WIDTH < 1 || WIDTH > GRAY_MAX_W) begin : g_bad_width
    $error("WIDTH must be 1..256");
  end
  assign s = sync_q[STAGES-1];
  assign b = WIDTH'(gray2bin(GRAY_MAX_W'(s)));
  always_comb begin
    cnt_d = (s != p_q) ? '0 : (cnt_q == CW'(STABLE_CYCLES)) ? cnt_q : cnt_q + 1'b1;
    accept = (MODE == CDC_MODE_GRAY) ? 1'b1 : (s == p_q) && (cnt_q == CW'(STABLE_CYCLES - 1));
    nxt = (MODE == CDC_MODE_GRAY) ? b : s;
    dst_load = accept && (nxt != dst_data || !dst_valid);
  end
  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= RESET_VAL;
    end else begin
      sync_q[0] <= async_data;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      p_q <= RESET_VAL;
      cnt_q <= '0;
      dst_data <= RESET_VAL;
      dst_valid <= 1'b0;
      dst_update <= 1'b0;
    end else begin
      p_q <= s;
      cnt_q <= cnt_d;
      if (dst_load) dst_data <= nxt;
      dst_valid <= dst_valid | accept;
      dst_update <= dst_load;
    end
  end
endmodule

// File: rtl/piradip_cdc_stable_bus.sv
// piradip_cdc_stable_bus: multi-channel filtered CDC of quasi-static buses
module piradip_cdc_stable_bus
  import piradip_cdc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHANNELS = 4,
  parameter int STAGES = 4,
  parameter int STABLE_CYCLES = 4,
  parameter cdc_mode_t MODE = CDC_MODE_STABLE,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      dst_clk,
  input  logic                      dst_rst_n,
  input  logic [CHANNELS*WIDTH-1:0] async_data,
  output logic [CHANNELS*WIDTH-1:0] dst_data,
  output logic [CHANNELS-1:0]       dst_update,
  output logic [CHANNELS-1:0]       dst_valid,
  output logic                      dst_any_update
);
  logic [CHANNELS-1:0] load;
  if (CHANNELS < 1) begin : g_bad_channels
    $error("CHANNELS must be at least 1");
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    piradip_cdc_stable_chan #(
      .WIDTH(WIDTH),
      .STAGES(STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .MODE(MODE),
      .RESET_VAL(RESET_VAL)
    ) u_chan (
      .dst_clk(dst_clk),
      .dst_rst_n(dst_rst_n),
      .async_data(async_data[c*WIDTH +: WIDTH]),
      .dst_data(dst_data[c*WIDTH +: WIDTH]),
      .dst_load(load[c]),
      .dst_update(dst_update[c]),
      .dst_valid(dst_valid[c])
    );
  end
  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) dst_any_update <= 1'b0;
    else dst_any_update <= |load;
  end
endmodule

// File: tb/tb_piradip_cdc_stable_bus.sv
// tb_piradip_cdc_stable_bus: directed checks of stable and gray mode CDC bus
module tb_piradip_cdc_stable_bus;
  import piradip_cdc_pkg::*;
  logic dst_clk = 1'b0;
  logic dst_rst_n;
  logic [63:0] async_data, dst_data;
  logic [3:0] dst_update, dst_valid;
  logic dst_any_update;
  logic [7:0] g_async, g_data;
  logic [0:0] g_upd, g_valid;
  logic g_any;
  int compared = 0;
  int mismatched = 0;
  int upd_cnt [4];
  int any_cnt = 0, any_bad = 0, g_cnt = 0, g_bad = 0, g_expect = 0, alt_ph = 0, lat = 0;
  logic alt_en = 1'b0;
  logic seen;
  always #5 dst_clk = ~dst_clk;
  piradip_cdc_stable_bus #(
    .WIDTH(16), .CHANNELS(4), .STAGES(2), .STABLE_CYCLES(4),
    .MODE(CDC_MODE_STABLE), .RESET_VAL(16'h0000)
  ) u_dut (
    .dst_clk(dst_clk), .dst_rst_n(dst_rst_n), .async_data(async_data),
    .dst_data(dst_data), .dst_update(dst_update), .dst_valid(dst_valid),
    .dst_any_update(dst_any_update)
  );
  piradip_cdc_stable_bus #(
    .WIDTH(8), .CHANNELS(1), .STAGES(2), .STABLE_CYCLES(4),
    .MODE(CDC_MODE_GRAY), .RESET_VAL(8'h00)
  ) u_gray (
    .dst_clk(dst_clk), .dst_rst_n(dst_rst_n), .async_data(g_async),
    .dst_data(g_data), .dst_update(g_upd), .dst_valid(g_valid),
    .dst_any_update(g_any)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge dst_clk);
    for (int c = 0; c < 4; c++) upd_cnt[c] += int'(dst_update[c]);
    any_cnt += int'(dst_any_update);
    if (dst_any_update !== (|dst_update)) any_bad++;
    if (g_upd[0]) begin
      if (g_data !== 8'(g_expect)) g_bad++;
      g_expect++;
      g_cnt++;
    end
    if (alt_en) begin
      alt_ph++;
      if (alt_ph % 2 == 0) async_data[31:16] = (async_data[31:16] == 16'h00A5) ? 16'h005A : 16'h00A5;
    end
  endtask
  initial begin
    for (int c = 0; c < 4; c++) upd_cnt[c] = 0;
    dst_rst_n = 1'b0;
    async_data = '0;
    async_data[31:16] = 16'h00A5;
    g_async = '0;
    repeat (3) tick();
    check("rst_data", dst_data, 64'h0);
    check("rst_valid", 64'(dst_valid), 64'h0);
    check("rst_update", 64'(dst_update), 64'h0);
    check("rst_any", 64'(dst_any_update), 64'h0);
    check("rst_gvalid", 64'(g_valid), 64'h0);
    alt_en = 1'b1;
    dst_rst_n = 1'b1;
    repeat (50) tick();
    alt_en = 1'b0;
    check("alt_upd1", 64'(upd_cnt[1]), 64'd0);
    check("alt_valid1", 64'(dst_valid[1]), 64'd0);
    check("boot_valid", 64'(dst_valid), 64'hD);
    check("boot_upd0", 64'(upd_cnt[0]), 64'd1);
    for (int v = 0; v < 256; v++) begin
      g_async = 8'(v ^ (v >> 1));
      repeat (3) tick();
    end
    repeat (6) tick();
    check("gray_pulses", 64'(g_cnt), 64'd256);
    check("gray_seq_errs", 64'(g_bad), 64'd0);
    check("gray_final", 64'(g_data), 64'd255);
    check("gray_valid", 64'(g_valid), 64'd1);
    upd_cnt[0] = 0;
    async_data[15:0] = 16'h1234;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick();
      if (dst_update[0]) begin
        seen = 1'b1;
        lat = i;
      end
    end
    check("step_seen", 64'(seen), 64'd1);
    check("step_latency_6to8", 64'(lat >= 6 && lat <= 8), 64'd1);
    check("step_data", 64'(dst_data[15:0]), 64'h1234);
    check("step_valid", 64'(dst_valid[0]), 64'd1);
    repeat (10) tick();
    check("step_once", 64'(upd_cnt[0]), 64'd1);
    upd_cnt[0] = 0;
    async_data[15:0] = 16'h0010;
    repeat (12) tick();
    check("pre_glitch_upd", 64'(upd_cnt[0]), 64'd1);
    upd_cnt[0] = 0;
    async_data[15:0] = 16'h0011;
    repeat (2) tick();
    async_data[15:0] = 16'h0010;
    repeat (15) tick();
    check("glitch_upd", 64'(upd_cnt[0]), 64'd0);
    check("glitch_data", 64'(dst_data[15:0]), 64'h0010);
    any_cnt = 0;
    async_data = 64'h4444_3333_2222_1111;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick();
      if (dst_any_update) seen = 1'b1;
    end
    check("all_seen", 64'(seen), 64'd1);
    check("all_update", 64'(dst_update), 64'hF);
    tick();
    check("all_update_off", 64'(dst_update), 64'h0);
    check("all_any_off", 64'(dst_any_update), 64'd0);
    repeat (10) tick();
    check("all_any_count", 64'(any_cnt), 64'd1);
    check("all_data", dst_data, 64'h4444_3333_2222_1111);
    async_data[47:32] = 16'h0077;
    repeat (5) tick();
    dst_rst_n = 1'b0;
    #1;
    check("midrst_data", dst_data, 64'h0);
    check("midrst_valid", 64'(dst_valid), 64'h0);
    check("midrst_update", 64'(dst_update), 64'h0);
    check("midrst_any", 64'(dst_any_update), 64'h0);
    repeat (2) tick();
    dst_rst_n = 1'b1;
    seen = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick();
      if (dst_update[2]) begin
        seen = 1'b1;
        lat = i;
      end
    end
    check("rel_seen", 64'(seen), 64'd1);
    check("rel_latency_6to8", 64'(lat >= 6 && lat <= 8), 64'd1);
    check("rel_data2", 64'(dst_data[47:32]), 64'h0077);
    check("any_matches_or", 64'(any_bad), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
